// File: rtl/nibble_serial_add_ctrl.sv
// Nibble-serial wide adder controller: streams operand nibbles LSB-first through an
// external combinational 4-bit adder slice, chains its carry and assembles the sum.
module nibble_serial_add_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic [3:0]       slc_a,
  output logic [3:0]       slc_b,
  output logic             slc_cin,
  input  logic [3:0]       slc_sum,
  input  logic             slc_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             busy
);

  localparam int NSLICE = WIDTH / 4;
  localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(NSLICE - 1);

  generate
    if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
      $error("nibble_serial_add_ctrl: WIDTH must be a multiple of 4 and at least 4");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  // Operands and result viewed as nibble arrays so the counter indexes them directly.
  logic [NSLICE-1:0][3:0] r_a;
  logic [NSLICE-1:0][3:0] r_b;
  logic [NSLICE-1:0][3:0] r_res;
  logic                   r_carry;
  logic [CNT_W-1:0]       r_cnt;

  logic w_accept;
  logic w_step;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_step    = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    slc_a     = 4'h0;
    slc_b     = 4'h0;
    slc_cin   = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_accept = 1'b1;
          w_next   = S_RUN;
        end
      end
      S_RUN: begin
        busy    = 1'b1;
        w_step  = 1'b1;
        slc_a   = r_a[r_cnt];
        slc_b   = r_b[r_cnt];
        slc_cin = r_carry;
        if (r_cnt == LAST_NIB) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // NOTE: operand/result storage is reset because out_sum exposes it and must read 0 after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_a     <= in_a;
      r_b     <= in_b;
      r_carry <= in_cin;
      r_cnt   <= '0;
    end else if (w_step) begin
      r_res[r_cnt] <= slc_sum;
      r_carry      <= slc_cout;
      r_cnt        <= (r_cnt == LAST_NIB) ? '0 : r_cnt + 1'b1;
    end
  end

  // Result and carry only change in RUN, so they are frozen while DONE waits on out_ready.
  assign out_sum  = r_res;
  assign out_cout = r_carry;

endmodule

// File: doc/nibble_serial_add_ctrl.md
Name: nibble_serial_add_ctrl

Overview:
- Multi-cycle wide adder controller that sits directly upstream of the team's 4-bit carry-skip adder slice and also consumes its result.
- Accepts WIDTH-bit operand pairs over a valid/ready handshake and feeds one 4-bit nibble pair per cycle into the external slice, least-significant nibble first.
- Chains the slice carry-out back into the next nibble's carry-in, assembles the WIDTH-bit sum, and presents sum plus final carry over a valid/ready output handshake.

Parameters:
WIDTH, 16, operand/sum width in bits; must be a multiple of 4 and at least 4 (elaboration error otherwise)
NSLICE, WIDTH/4, derived nibble count; not to be overridden

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand pair valid
in_ready  output  1  block can accept operands
in_a  input  WIDTH  operand A
in_b  input  WIDTH  operand B
in_cin  input  1  carry-in for nibble 0
slc_a  output  4  nibble of A to slice
slc_b  output  4  nibble of B to slice
slc_cin  output  1  carry into slice
slc_sum  input  4  slice sum (combinational from slc_*)
slc_cout  input  1  slice carry-out (combinational from slc_*)
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out_sum  output  WIDTH  assembled sum
out_cout  output  1  carry-out of the top nibble
busy  output  1  high in RUN or DONE

Behaviour:
- Clock and reset: single clock; reset is asynchronous, active-low (rst_n), released synchronously to clk by the system.
- Reset values:
  - state = IDLE.
  - Operand registers, result register, carry register and nibble counter = 0.
  - out_valid = 0, out_sum = 0, out_cout = 0, busy = 0.
  - in_ready = 1 once in IDLE.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: latch in_a, in_b, in_cin; clear counter; go to RUN.
- RUN (exactly NSLICE cycles):
  - Nibble k is driven from registers: slc_a = A[4k+3:4k], slc_b = B[4k+3:4k].
  - slc_cin = carry register (k = 0: latched in_cin).
  - At each edge: result[4k+3:4k] <= slc_sum, carry <= slc_cout, k <= k+1.
  - After the edge with k = NSLICE-1, go to DONE.
- DONE:
  - out_valid = 1; out_sum = result register; out_cout = final carry.
  - On out_valid & out_ready: go to IDLE.
- Outputs are registered. out_sum and out_cout are held stable while out_valid & !out_ready.
- Slice drive outside RUN: slc_a, slc_b and slc_cin are driven 0 in IDLE and DONE.
- Latency: accept edge E; out_valid rises after edge E+NSLICE.
- Minimum initiation interval: NSLICE+2 cycles. in_ready is 0 in RUN and DONE, including the DONE cycle in which out_ready = 1; there is no accept/complete overlap.
- in_valid while in_ready = 0 is ignored. Upstream must hold in_valid and its data until it sees the handshake.
- Arithmetic: {out_cout, out_sum} == in_a + in_b + in_cin, modulo 2^(WIDTH+1).
- The carry register holds exactly 1 bit; there is no overflow flag.
- The slice is purely combinational. The block relies on slc_sum and slc_cout settling within one clock period; no pipeline register sits between slc_* and slc_sum/slc_cout.
- Reset mid-operation (RUN or DONE): the operation is aborted with no output and the block returns to reset values; in_ready is 1 after rst_n deasserts.
- Counter wraps only via the RUN->DONE transition. Its width is enough to hold NSLICE-1.

Test Plan:
- WIDTH=16: in_a=0x1234, in_b=0x4321, in_cin=0 -> out_sum=0x5555, out_cout=0. out_valid rises 4 cycles after the accept edge; slc_a sequence is 4,3,2,1.
- WIDTH=16: 0xFFFF + 0x0001, cin 0 -> out_sum=0x0000, out_cout=1. slc_cin sequence is 0,1,1,1.
- WIDTH=16: 0x0F0F + 0xF0F0, cin 1 (every nibble fully propagating) -> out_sum=0x0000, out_cout=1. slc_cin=1 on every RUN cycle.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while in_valid=1 with new data. out_sum/out_cout stay unchanged and in_ready stays 0. After out_ready=1, next cycle is IDLE and the new operands are accepted.
- Reset: assert rst_n=0 on the 2nd RUN cycle. All outputs return to reset values immediately (asynchronously); out_valid never asserts for the aborted operation. The next operand pair after release completes correctly.
- Random: 1000 random operands/cin with random in_valid/out_ready gaps, for WIDTH=4, 8 and 16. Every result matches the reference sum a+b+cin, and the number of results equals the number of accepts.
